// File: rtl/matrix_operand_loader.sv
// matrix_operand_loader
//
// Collects a 32-element row-major stream into two 4x4 operand matrices
// (elements 0-15 -> matrix_1, elements 16-31 -> matrix_2). It then presents the
// pair to a downstream MAC stage with a valid/ready handshake.
//
// Ports:
//   clock_i        rising-edge clock
//   reset_i        synchronous active-high reset
//   clear_i        synchronous frame abort (drops any frame in progress or pending)
//   in_valid_i     stream element valid
//   in_ready_o     loader can accept an element
//   in_data_i      stream element
//   in_last_i      marks element 31 of a frame
//   out_valid_o    both operand matrices complete and stable
//   out_ready_i    downstream consumes the operand pair
//   matrix_1_o     operand A, [row][col]
//   matrix_2_o     operand B, [row][col]
//   mac_enable_o   one-cycle accumulate strobe (handoff)
//   pair_count_o   number of operand pairs handed off (wraps at 16 bits)
//   err_o          sticky framing error
//
// Build option:
//   MATRIX_LOADER_FRAME_CHECK_EN  compiles in the in_last framing check. Without
//                                 it, in_last is ignored and err_o is tied to 0.

module matrix_operand_loader #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                               clock_i,
    input  logic                               reset_i,
    input  logic                               clear_i,
    input  logic                               in_valid_i,
    output logic                               in_ready_o,
    input  logic [DATA_WIDTH-1:0]              in_data_i,
    input  logic                               in_last_i,
    output logic                               out_valid_o,
    input  logic                               out_ready_i,
    output logic [0:3][0:3][DATA_WIDTH-1:0]    matrix_1_o,
    output logic [0:3][0:3][DATA_WIDTH-1:0]    matrix_2_o,
    output logic                               mac_enable_o,
    output logic [15:0]                        pair_count_o,
    output logic                               err_o
);

    typedef enum logic [1:0] {
        StLoadA,
        StLoadB,
        StPresent
    } state_e;

    state_e                            state_q;
    logic [3:0]                        idx_q;
    logic [0:3][0:3][DATA_WIDTH-1:0]   mat1_q;
    logic [0:3][0:3][DATA_WIDTH-1:0]   mat2_q;
    logic [15:0]                       pair_count_q;
    logic                              err_q;

    logic loading;
    logic beat;
    logic last_elem;
    logic frame_err;

    always_comb begin
        loading      = (state_q == StLoadA) || (state_q == StLoadB);
        // Reset and clear both block acceptance and presentation in the same cycle,
        // so neither a beat nor a handoff can slip through alongside them.
        in_ready_o   = loading && !clear_i && !reset_i;
        beat         = in_valid_i && in_ready_o;
        out_valid_o  = (state_q == StPresent) && !clear_i && !reset_i;
        mac_enable_o = out_valid_o && out_ready_i;
        last_elem    = (state_q == StLoadB) && (idx_q == 4'd15);
`ifdef MATRIX_LOADER_FRAME_CHECK_EN
        frame_err    = beat && (in_last_i != last_elem);
`else
        frame_err    = 1'b0;
`endif
    end

`ifndef MATRIX_LOADER_FRAME_CHECK_EN
    logic unused_in_last;
    assign unused_in_last = in_last_i;
`endif

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q      <= StLoadA;
            idx_q        <= 4'd0;
            mat1_q       <= '0;
            mat2_q       <= '0;
            pair_count_q <= 16'd0;
            err_q        <= 1'b0;
        end else if (clear_i) begin
            // Matrices and pair_count are deliberately left untouched.
            state_q <= StLoadA;
            idx_q   <= 4'd0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                StLoadA: begin
                    if (beat) begin
                        mat1_q[idx_q[3:2]][idx_q[1:0]] <= in_data_i;
                        if (frame_err) begin
                            state_q <= StLoadA;
                            idx_q   <= 4'd0;
                            err_q   <= 1'b1;
                        end else begin
                            // idx wraps 15 -> 0 on the move to matrix_2.
                            idx_q <= idx_q + 4'd1;
                            if (idx_q == 4'd15) begin
                                state_q <= StLoadB;
                            end
                        end
                    end
                end
                StLoadB: begin
                    if (beat) begin
                        mat2_q[idx_q[3:2]][idx_q[1:0]] <= in_data_i;
                        if (frame_err) begin
                            state_q <= StLoadA;
                            idx_q   <= 4'd0;
                            err_q   <= 1'b1;
                        end else begin
                            idx_q <= idx_q + 4'd1;
                            if (last_elem) begin
                                state_q <= StPresent;
                            end
                        end
                    end
                end
                StPresent: begin
                    if (mac_enable_o) begin
                        pair_count_q <= pair_count_q + 16'd1;
                        state_q      <= StLoadA;
                        idx_q        <= 4'd0;
                    end
                end
                default: begin
                    state_q <= StLoadA;
                    idx_q   <= 4'd0;
                end
            endcase
        end
    end

    assign matrix_1_o   = mat1_q;
    assign matrix_2_o   = mat2_q;
    assign pair_count_o = pair_count_q;

`ifdef MATRIX_LOADER_FRAME_CHECK_EN
    assign err_o = err_q;
`else
    logic unused_err;
    assign unused_err = err_q;
    assign err_o      = 1'b0;
`endif

endmodule
